// File: rtl/div_pkg.sv
// Shared defaults and entry-width helpers for the divider issue front end.
// Build option: DIV_ISSUER_DBZ_EN adds divide-by-zero fixup (dbz flag + stored dividend).
package div_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned TAGW_DEF  = 4;

`ifdef DIV_ISSUER_DBZ_EN
  localparam bit DBZ_EN = 1'b1;
`else
  localparam bit DBZ_EN = 1'b0;
`endif

  // Tag FIFO entry: {tag, dbz, a} with fixup, {tag} without.
  function automatic int unsigned tag_entry_w(input int unsigned xlen, input int unsigned tagw);
    return DBZ_EN ? (tagw + 1 + xlen) : tagw;
  endfunction

  // Result FIFO entry: {quo, rem, tag, dbz} with fixup, {quo, rem, tag} without.
  function automatic int unsigned res_entry_w(input int unsigned xlen, input int unsigned tagw);
    return DBZ_EN ? (2 * xlen + tagw + 1) : (2 * xlen + tagw);
  endfunction

endpackage

// File: rtl/div_fifo.sv
// Synchronous FIFO with registered storage; push is accepted on a full FIFO
// when a pop happens in the same cycle.
module div_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/div_issuer.sv
// Issues divide requests to a fixed-latency-free divfunc, tracks tags in order and
// buffers results for a backpressured response port. Option: DIV_ISSUER_DBZ_EN.
module div_issuer
  import div_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned TAGW  = TAGW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_vld,
  output logic            req_rdy,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic [TAGW-1:0] req_tag,
  output logic            div_vld,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  input  logic [XLEN-1:0] div_quo,
  input  logic [XLEN-1:0] div_rem,
  input  logic            div_ack,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic [XLEN-1:0] rsp_quo,
  output logic [XLEN-1:0] rsp_rem,
  output logic [TAGW-1:0] rsp_tag,
  output logic            rsp_dbz,
  output logic            err
);

  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam int unsigned TEW  = tag_entry_w(XLEN, TAGW);
  localparam int unsigned REW  = res_entry_w(XLEN, TAGW);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            req_rdy_q, req_rdy_d;
  logic            div_vld_q, div_vld_d;
  logic [XLEN-1:0] div_a_q, div_a_d;
  logic [XLEN-1:0] div_b_q, div_b_d;

  logic            accept, rsp_pop, ack_ok, ack_err;
  logic [TEW-1:0]  tag_wdata, tag_rdata;
  logic [REW-1:0]  res_wdata, res_rdata;
  logic            tag_full, tag_empty, res_full, res_empty;
  logic [TAGW-1:0] head_tag;

  assign accept  = req_vld && req_rdy_q;
  assign rsp_pop = rsp_vld && rsp_rdy;
  assign ack_ok  = div_ack && !tag_empty;
  assign ack_err = div_ack && tag_empty;

  assign req_rdy = req_rdy_q;
  assign div_vld = div_vld_q;
  assign div_a   = div_a_q;
  assign div_b   = div_b_q;
  assign err     = err_q;
  assign rsp_vld = !res_empty;
  assign rsp_quo = res_rdata[REW-1 -: XLEN];
  assign rsp_rem = res_rdata[REW-XLEN-1 -: XLEN];

`ifdef DIV_ISSUER_DBZ_EN
  logic            head_dbz;
  logic [XLEN-1:0] head_a;

  assign tag_wdata = {req_tag, (req_b == '0), req_a};
  assign head_tag  = tag_rdata[TEW-1 -: TAGW];
  assign head_dbz  = tag_rdata[XLEN];
  assign head_a    = tag_rdata[XLEN-1:0];
  // Divide-by-zero entries replace the divfunc result with the architectural fixup.
  assign res_wdata = {(head_dbz ? {XLEN{1'b1}} : div_quo),
                      (head_dbz ? head_a : div_rem),
                      head_tag, head_dbz};
  assign rsp_tag   = res_rdata[TAGW:1];
  assign rsp_dbz   = res_rdata[0];
`else
  assign tag_wdata = req_tag;
  assign head_tag  = tag_rdata;
  assign res_wdata = {div_quo, div_rem, head_tag};
  assign rsp_tag   = res_rdata[TAGW-1:0];
  assign rsp_dbz   = 1'b0;
`endif

  // Credits cover both in-flight and buffered entries, so the result FIFO cannot overflow.
  always_comb begin
    cnt_d     = cnt_q;
    err_d     = err_q | ack_err;
    div_vld_d = accept;
    div_a_d   = div_a_q;
    div_b_d   = div_b_q;
    case ({accept, rsp_pop})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (accept) begin
      div_a_d = req_a;
      div_b_d = req_b;
    end
    req_rdy_d = (cnt_d < CNTW'(DEPTH)) && !err_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      err_q     <= 1'b0;
      req_rdy_q <= 1'b0;
      div_vld_q <= 1'b0;
      div_a_q   <= '0;
      div_b_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      req_rdy_q <= req_rdy_d;
      div_vld_q <= div_vld_d;
      div_a_q   <= div_a_d;
      div_b_q   <= div_b_d;
    end
  end

  div_fifo #(.WIDTH(TEW), .DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .wdata_i (tag_wdata),
    .pop_i   (ack_ok),
    .rdata_o (tag_rdata),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  div_fifo #(.WIDTH(REW), .DEPTH(DEPTH)) u_res_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (ack_ok),
    .wdata_i (res_wdata),
    .pop_i   (rsp_pop),
    .rdata_o (res_rdata),
    .full_o  (res_full),
    .empty_o (res_empty)
  );

  // Full flags are implied by the credit count; kept only for visibility.
  logic unused_full;
  assign unused_full = tag_full ^ res_full;

endmodule

// File: tb/tb_div_issuer.sv
// Directed bench for div_issuer with a small 2-stage divfunc model that resets with rst_n.
module tb_div_issuer;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAGW  = 4;

  typedef struct packed {
    logic [31:0] quo;
    logic [31:0] rem;
    logic [3:0]  tag;
    logic        dbz;
  } rsp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_vld = 1'b0;
  logic            req_rdy;
  logic [XLEN-1:0] req_a = '0, req_b = '0;
  logic [TAGW-1:0] req_tag = '0;
  logic            div_vld;
  logic [XLEN-1:0] div_a, div_b, div_quo, div_rem;
  logic            div_ack;
  logic            rsp_vld;
  logic            rsp_rdy = 1'b0;
  logic [XLEN-1:0] rsp_quo, rsp_rem;
  logic [TAGW-1:0] rsp_tag;
  logic            rsp_dbz;
  logic            err;
  logic            force_ack = 1'b0;

  int   n_vec = 0, n_err = 0;
  int   sent_n = 0, got_n = 0, max_out = 0, div_pulses = 0;
  rsp_t exp_q[$];
  rsp_t got_q[$];
  rsp_t mon_r;
  logic stream_done;

  always #5 clk = ~clk;

  div_issuer #(.XLEN(XLEN), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .div_vld(div_vld), .div_a(div_a), .div_b(div_b),
    .div_quo(div_quo), .div_rem(div_rem), .div_ack(div_ack),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .rsp_quo(rsp_quo), .rsp_rem(rsp_rem), .rsp_tag(rsp_tag), .rsp_dbz(rsp_dbz),
    .err(err)
  );

  // divfunc model: two-cycle pipeline, returns a marker pattern for a zero divisor.
  logic        s0_v, s1_v;
  logic [31:0] s0_a, s0_b, s1_a, s1_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_v <= 1'b0; s1_v <= 1'b0;
      s0_a <= '0; s0_b <= '0; s1_a <= '0; s1_b <= '0;
    end else begin
      s0_v <= div_vld; s0_a <= div_a; s0_b <= div_b;
      s1_v <= s0_v;    s1_a <= s0_a;  s1_b <= s0_b;
    end
  end
  assign div_ack = s1_v | force_ack;
  assign div_quo = (s1_b == 0) ? 32'h0BAD_0BAD : s1_a / s1_b;
  assign div_rem = (s1_b == 0) ? 32'h0000_1234 : s1_a % s1_b;

  function automatic rsp_t ref_rsp(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    rsp_t r;
    r.tag = t;
    r.dbz = 1'b0;
    if (b == 0) begin
`ifdef DIV_ISSUER_DBZ_EN
      r.quo = 32'hFFFF_FFFF; r.rem = a; r.dbz = 1'b1;
`else
      r.quo = 32'h0BAD_0BAD; r.rem = 32'h0000_1234;
`endif
    end else begin
      r.quo = a / b; r.rem = a % b;
    end
    return r;
  endfunction

  // Transaction monitor, sampled on the active edge before the DUT updates.
  always @(posedge clk) begin
    if (rst_n) begin
      if (req_vld && req_rdy) begin
        exp_q.push_back(ref_rsp(req_a, req_b, req_tag));
        sent_n++;
      end
      if (rsp_vld && rsp_rdy) begin
        mon_r.quo = rsp_quo; mon_r.rem = rsp_rem; mon_r.tag = rsp_tag; mon_r.dbz = rsp_dbz;
        got_q.push_back(mon_r);
        got_n++;
      end
      if (div_vld) div_pulses++;
      if (sent_n - got_n > max_out) max_out = sent_n - got_n;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input rsp_t g, input rsp_t e);
    chk({tag, ".quo"}, 64'(g.quo), 64'(e.quo));
    chk({tag, ".rem"}, 64'(g.rem), 64'(e.rem));
    chk({tag, ".tag"}, 64'(g.tag), 64'(e.tag));
    chk({tag, ".dbz"}, 64'(g.dbz), 64'(e.dbz));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_vld = 1'b0; force_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.req_rdy", 64'(req_rdy), 64'd0);
    chk("rst.rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst.div_vld", 64'(div_vld), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    chk("rst.payload", {rsp_quo, rsp_rem}, 64'd0);
    chk("rst.div_ab", {div_a, div_b}, 64'd0);
    exp_q.delete(); got_q.delete();
    sent_n = 0; got_n = 0; div_pulses = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.req_rdy_after", 64'(req_rdy), 64'd1);
    @(negedge clk);
  endtask

  // Present a request and hold it until accepted; returns on the negedge after acceptance.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    int w = 0;
    req_vld = 1'b1; req_a = a; req_b = b; req_tag = t;
    while (!req_rdy && w < 200) begin
      @(negedge clk); w++;
    end
    if (w >= 200) chk("send.timeout", 64'd1, 64'd0);
    @(negedge clk);
    req_vld = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int n);
    for (int i = 0; i < 400 && got_q.size() < n; i++) @(negedge clk);
    chk({tag, ".count"}, 64'(got_q.size()), 64'(n));
  endtask

  localparam logic [31:0] Q037 [4] = '{32'd100, 32'd50, 32'd34, 32'd25};
  localparam logic [31:0] R037 [4] = '{32'd0, 32'd1, 32'd0, 32'd3};

  initial begin
    rsp_t e;
    int   held_sent;
    do_reset();

    // Single request 625/5.
    rsp_rdy = 1'b1;
    send(32'd625, 32'd5, 4'd3);
    chk("t1.div_vld", 64'(div_vld), 64'd1);
    chk("t1.div_a", 64'(div_a), 64'd625);
    chk("t1.div_b", 64'(div_b), 64'd5);
    @(negedge clk);
    chk("t1.div_vld_pulse", 64'(div_vld), 64'd0);
    wait_rsp("t1", 1);
    e = '{quo: 32'd125, rem: 32'd0, tag: 4'd3, dbz: 1'b0};
    if (got_q.size() > 0) chk_rsp("t1", got_q[0], e);
    chk("t1.pulses", 64'(div_pulses), 64'd1);

    // Fill with the consumer stalled: DEPTH accepted, then backpressure.
    do_reset();
    rsp_rdy = 1'b0;
    for (int i = 0; i <= int'(DEPTH); i++) begin
      req_vld = 1'b1; req_a = 32'(100 + i); req_b = 32'(i + 1); req_tag = 4'(i);
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk("t2.accepted", 64'(sent_n), 64'(DEPTH));
    chk("t2.req_rdy", 64'(req_rdy), 64'd0);
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    wait_rsp("t2", int'(DEPTH));
    for (int i = 0; i < int'(DEPTH) && i < got_q.size(); i++) begin
      e = '{quo: Q037[i], rem: R037[i], tag: 4'(i), dbz: 1'b0};
      chk_rsp($sformatf("t2.rsp%0d", i), got_q[i], e);
    end
    repeat (8) @(negedge clk);
    chk("t2.no_extra", 64'(got_q.size()), 64'(DEPTH));

    // Divide-by-zero sandwiched between normal requests.
    do_reset();
    rsp_rdy = 1'b1;
    send(32'd100, 32'd3, 4'd5);
    send(32'd7, 32'd0, 4'd6);
    send(32'd9, 32'd2, 4'd7);
    wait_rsp("t3", 3);
    if (got_q.size() >= 3) begin
      chk_rsp("t3.r0", got_q[0], '{quo: 32'd33, rem: 32'd1, tag: 4'd5, dbz: 1'b0});
`ifdef DIV_ISSUER_DBZ_EN
      chk_rsp("t3.r1", got_q[1], '{quo: 32'hFFFF_FFFF, rem: 32'd7, tag: 4'd6, dbz: 1'b1});
`else
      chk_rsp("t3.r1", got_q[1], '{quo: 32'h0BAD_0BAD, rem: 32'h0000_1234, tag: 4'd6, dbz: 1'b0});
`endif
      chk_rsp("t3.r2", got_q[2], '{quo: 32'd4, rem: 32'd1, tag: 4'd7, dbz: 1'b0});
    end

    // Stream with the consumer toggling every cycle.
    do_reset();
    max_out = 0;
    stream_done = 1'b0;
    rsp_rdy = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send(32'(1000 * i + 7), 32'(i % 5), 4'(i));
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(negedge clk);
          rsp_rdy = ~rsp_rdy;
        end
      end
    join
    rsp_rdy = 1'b1;
    wait_rsp("t4", 20);
    for (int i = 0; i < 20 && i < got_q.size(); i++)
      chk_rsp($sformatf("t4.rsp%0d", i), got_q[i], exp_q[i]);
    repeat (8) @(negedge clk);
    chk("t4.no_dup", 64'(got_q.size()), 64'd20);
    chk("t4.max_out_le_depth", 64'(max_out <= int'(DEPTH)), 64'd1);

    // Reset with requests in flight, then a clean request.
    rsp_rdy = 1'b0;
    send(32'd81, 32'd9, 4'd1);
    send(32'd64, 32'd8, 4'd2);
    do_reset();
    chk("t5.rsp_vld", 64'(rsp_vld), 64'd0);
    rsp_rdy = 1'b1;
    send(32'd50, 32'd7, 4'd9);
    wait_rsp("t5", 1);
    if (got_q.size() > 0)
      chk_rsp("t5.r0", got_q[0], '{quo: 32'd7, rem: 32'd1, tag: 4'd9, dbz: 1'b0});
    repeat (6) @(negedge clk);
    chk("t5.no_stale", 64'(got_q.size()), 64'd1);

    // Spurious ack: sticky error, requests blocked, ack ignored.
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    chk("t6.err", 64'(err), 64'd1);
    chk("t6.req_rdy", 64'(req_rdy), 64'd0);
    held_sent = sent_n;
    req_vld = 1'b1; req_a = 32'd10; req_b = 32'd2; req_tag = 4'd4;
    repeat (5) @(negedge clk);
    req_vld = 1'b0;
    chk("t6.err_sticky", 64'(err), 64'd1);
    chk("t6.no_accept", 64'(sent_n), 64'(held_sent));
    chk("t6.rsp_vld", 64'(rsp_vld), 64'd0);
    do_reset();
    chk("t6.err_cleared", 64'(err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/div_issuer.md
DIV_ISSUER -- requirements
Module: div_issuer

Interface
REQ-001 Parameter XLEN, default 32, operand/result width.
REQ-002 Parameter DEPTH, default 4, max requests held (in flight + buffered); power of two, >=2.
REQ-003 Parameter TAGW, default 4, request tag width.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_vld  in  1  upstream request valid.
REQ-007 req_rdy  out  1  request accepted this cycle when req_vld && req_rdy.
REQ-008 req_a, req_b, req_tag  in  XLEN, XLEN, TAGW  dividend, divisor, tag.
REQ-009 div_vld  out  1  one-cycle issue pulse to divfunc.
REQ-010 div_a, div_b  out  XLEN  registered operands to divfunc.
REQ-011 div_quo, div_rem  in  XLEN  divfunc results.
REQ-012 div_ack  in  1  divfunc result valid; divfunc has no backpressure.
REQ-013 rsp_vld, rsp_rdy  out, in  1  downstream response handshake.
REQ-014 rsp_quo, rsp_rem, rsp_tag  out  XLEN, XLEN, TAGW  response payload.
REQ-015 rsp_dbz  out  1  response came from divide-by-zero request.
REQ-016 err  out  1  sticky: div_ack seen with no request outstanding.

Function
REQ-017 Credit counter cnt (0..DEPTH) = in-flight + buffered; req_rdy = (cnt < DEPTH) && !err.
REQ-018 On accept: next cycle div_vld=1 for exactly one cycle, div_a/div_b = accepted operands; {tag, dbz=(b==0), a} pushed to tag FIFO.
REQ-019 Back-to-back accepts issue on consecutive cycles; no bubble.
REQ-020 On div_ack: pop tag FIFO head, push {quo, rem, tag, dbz} to result FIFO the same cycle; results strictly in issue order.
REQ-021 Result FIFO never overflows: guaranteed by REQ-017, since div_ack cannot be stalled.
REQ-022 rsp_* driven from result FIFO head; rsp_vld = result FIFO non-empty; pop on rsp_vld && rsp_rdy.
REQ-023 rsp_* payload stable while rsp_vld && !rsp_rdy.
REQ-024 cnt +1 on accept, -1 on response pop; both same cycle -> unchanged.
REQ-025 div_ack and response pop in same cycle on a full result FIFO: legal, entries preserved in order.
REQ-026 div_ack with empty tag FIFO: ack ignored, err set to 1 and held until reset; no new requests accepted.
REQ-027 Fall-through latency: accept at cycle T, div_vld at T+1, rsp_vld one cycle after div_ack.

Reset
REQ-028 rst_n low: div_vld=0, req_rdy=0 while low, rsp_vld=0, err=0, cnt=0, both FIFOs empty, div_a/div_b/rsp payload=0.
REQ-029 Reset mid-operation discards all in-flight and buffered entries; downstream divfunc is reset by the same rst_n.
REQ-030 req_rdy=1 on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro DIV_ISSUER_DBZ_EN.
REQ-032 Defined: for dbz entries, response is rsp_quo = all ones, rsp_rem = stored dividend a, rsp_dbz=1; the divfunc result is discarded. The request is still issued to preserve ordering.
REQ-033 Undefined: divfunc result is passed through unchanged, rsp_dbz tied 0, and no dividend is stored in the tag FIFO.

Structure
REQ-034 Package div_pkg holds XLEN default, TAGW default, DEPTH default, and the tag/result entry field widths.
REQ-035 One sub-module div_fifo (synchronous FIFO, parameterized width/depth, push/pop/full/empty) instantiated twice: tag FIFO and result FIFO.

Verification
REQ-036 a=625, b=5, tag=3, rsp_rdy=1 -> one div_vld pulse; response quo=125, rem=0, tag=3, dbz=0.
REQ-037 rsp_rdy=0, DEPTH+1 requests offered back-to-back -> exactly DEPTH accepted, req_rdy=0 afterward; on releasing rsp_rdy, DEPTH responses in tag order 0..DEPTH-1.
REQ-038 With DIV_ISSUER_DBZ_EN: a=7, b=0 between a=100,b=3 and a=9,b=2 -> responses (33,1), (FFFFFFFF,7,dbz=1), (4,1) in order. Without the macro: divfunc output passed through, dbz=0.
REQ-039 Continuous stream with rsp_rdy toggling every cycle -> no loss, no duplication, cnt never exceeds DEPTH.
REQ-040 rst_n pulsed low with 2 requests in flight -> rsp_vld=0, cnt=0; next request returns a correct result.
REQ-041 Forced div_ack with nothing outstanding -> err=1 sticky, req_rdy=0 until reset.
